// File: rtl/refmem_pkg.sv
// Shared definitions for the block-RAM reference memory and its port sweeper:
// width codes, FSM states, mode codes, masks and the sweep pattern helper.
package refmem_pkg;

    typedef enum logic [2:0] {
        CFG_ILLEGAL = 3'd0,
        CFG_1BIT    = 3'd1,
        CFG_2BIT    = 3'd2,
        CFG_5BIT    = 3'd3,
        CFG_10BIT   = 3'd4,
        CFG_20BIT   = 3'd5,
        CFG_40BIT   = 3'd6,
        CFG_80BIT   = 3'd7
    } width_cfg_e;

    typedef enum logic [1:0] {
        CONFIG_SP           = 2'd0,
        CONFIG_TDP_NONSPLIT = 2'd1,
        CONFIG_TDP_SPLIT    = 2'd2,
        CONFIG_SDP          = 2'd3
    } ram_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } sweep_state_e;

    // With ECC on, the top 4 bits of every 20-bit group hold check bits, not data.
    localparam logic [79:0] ECCMASK = 80'h0FFFF_0FFFF_0FFFF_0FFFF;

    function automatic int unsigned width_bits(input logic [2:0] cfg);
        case (cfg)
            CFG_1BIT:  return 1;
            CFG_2BIT:  return 2;
            CFG_5BIT:  return 5;
            CFG_10BIT: return 10;
            CFG_20BIT: return 20;
            CFG_40BIT: return 40;
            CFG_80BIT: return 80;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [79:0] wmask(input logic [2:0] cfg);
        return (80'd1 << width_bits(cfg)) - 80'd1;
    endfunction

    function automatic logic [79:0] pattern(input logic [15:0] k, input logic [15:0] seed);
        return {5{k ^ seed}};
    endfunction

endpackage

// File: rtl/refmem_sweep_cmp.sv
// Read-side checker: delays each issued read by the memory latency, regenerates
// the expected pattern, does the masked compare and keeps the saturating results.
module refmem_sweep_cmp
    import refmem_pkg::*;
#(
    parameter int KW    = 17,
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             outreg_i,
    input  logic             ecc_i,
    input  logic [2:0]       width_i,
    input  logic [15:0]      seed_i,
    input  logic [KW-1:0]    lastK_i,
    input  logic             issueValid_i,
    input  logic [KW-1:0]    issueK_i,
    input  logic [15:0]      issueAddr_i,
    input  logic [79:0]      rddata_i,
    output logic             cmpLast_o,
    output logic [ERR_W-1:0] errCnt_o,
    output logic [15:0]      firstErrAddr_o
);
    typedef struct packed {
        logic          valid;
        logic [KW-1:0] k;
        logic [15:0]   addr;
    } pipe_t;

    pipe_t            stage0_q, stage1_q, sel;
    logic [79:0]      cmask, expected;
    logic             mismatch_d, mismatch_q;
    logic [15:0]      mmAddr_q;
    logic [ERR_W-1:0] errCnt_q;
    logic [15:0]      firstErr_q;

    always_comb begin
        sel        = outreg_i ? stage1_q : stage0_q;
        cmask      = wmask(width_i) & (ecc_i ? ECCMASK : {80{1'b1}});
        expected   = pattern(16'(sel.k), seed_i);
        mismatch_d = sel.valid && (|((rddata_i ^ expected) & cmask));
        cmpLast_o  = sel.valid && (sel.k == lastK_i);
    end

    // The compare result is registered at the compare edge; the counters follow one edge later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage0_q   <= '0;
            stage1_q   <= '0;
            mismatch_q <= 1'b0;
            mmAddr_q   <= '0;
            errCnt_q   <= '0;
            firstErr_q <= '0;
        end else begin
            stage0_q <= '{valid: issueValid_i, k: issueK_i, addr: issueAddr_i};
            stage1_q <= stage0_q;
            if (clear_i) begin
                mismatch_q <= 1'b0;
                mmAddr_q   <= '0;
                errCnt_q   <= '0;
                firstErr_q <= '0;
            end else begin
                mismatch_q <= mismatch_d;
                mmAddr_q   <= sel.addr;
                if (mismatch_q) begin
                    if (errCnt_q != {ERR_W{1'b1}}) begin
                        errCnt_q <= errCnt_q + ERR_W'(1);
                    end
                    if (errCnt_q == '0) begin
                        firstErr_q <= mmAddr_q;
                    end
                end
            end
        end
    end

    assign errCnt_o       = errCnt_q;
    assign firstErrAddr_o = firstErr_q;

endmodule

// File: rtl/refmem_port_sweeper.sv
// Port sweeper: writes a seeded pattern through one block-RAM port, reads it back
// and reports masked mismatches. FSM and address generation live here.
module refmem_port_sweeper
    import refmem_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       cfg_width_i,
    input  logic             cfg_outreg_i,
    input  logic             cfg_ecc_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [15:0]      cfg_seed_i,
    output logic             ram_cs_o,
    output logic             ram_we_o,
    output logic             ram_re_o,
    output logic [15:0]      ram_addr_o,
    output logic [79:0]      ram_wrdata_o,
    output logic [79:0]      ram_bitmask_o,
    input  logic [79:0]      ram_rddata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [15:0]      first_err_addr_o
);
    localparam int KW = LEN_W + 1;

    sweep_state_e  state_q;
    logic [2:0]    width_q;
    logic          outreg_q, ecc_q;
    logic [15:0]   seed_q;
    logic [KW-1:0] lastK_q, k_q, kInc, lastK_d;
    logic          cs_q, we_q, re_q, busy_q, done_q, cfgErr_q;
    logic [15:0]   addr_q, addrInc;
    logic [79:0]   wrdata_q, bitmask_q;
    logic [31:0]   depth, entries;
    logic          startAccept, cmpLast;

    always_comb begin
        depth   = 32'd65536 >> cfg_width_i;
        entries = (cfg_len_i == '0 || 32'(cfg_len_i) > depth) ? depth : 32'(cfg_len_i);
        lastK_d = KW'(entries - 32'd1);
    end

    assign kInc        = k_q + KW'(1);
    assign addrInc     = 16'(32'(kInc) << width_q);
    assign startAccept = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

    // Output registers always describe the access presented in the current cycle; k_q is its index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            width_q   <= '0;
            outreg_q  <= 1'b0;
            ecc_q     <= 1'b0;
            seed_q    <= '0;
            lastK_q   <= '0;
            k_q       <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            addr_q    <= '0;
            wrdata_q  <= '0;
            bitmask_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfgErr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        width_q  <= cfg_width_i;
                        outreg_q <= cfg_outreg_i;
                        ecc_q    <= cfg_ecc_i;
                        seed_q   <= cfg_seed_i;
                        lastK_q  <= lastK_d;
                        k_q      <= '0;
                        addr_q   <= '0;
                        cfgErr_q <= (cfg_width_i == CFG_ILLEGAL);
                        if (cfg_width_i == CFG_ILLEGAL) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_WRITE;
                            done_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            cs_q      <= 1'b1;
                            we_q      <= 1'b1;
                            re_q      <= 1'b0;
                            wrdata_q  <= pattern(16'd0, cfg_seed_i) & wmask(cfg_width_i);
                            bitmask_q <= wmask(cfg_width_i);
                        end
                    end
                end
                ST_WRITE: begin
                    if (k_q == lastK_q) begin
                        state_q   <= ST_READ;
                        k_q       <= '0;
                        addr_q    <= '0;
                        we_q      <= 1'b0;
                        re_q      <= 1'b1;
                        wrdata_q  <= '0;
                        bitmask_q <= '0;
                    end else begin
                        k_q      <= kInc;
                        addr_q   <= addrInc;
                        wrdata_q <= pattern(16'(kInc), seed_q) & wmask(width_q);
                    end
                end
                ST_READ: begin
                    if (k_q == lastK_q) begin
                        state_q <= ST_DRAIN;
                        cs_q    <= 1'b0;
                        re_q    <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        k_q    <= kInc;
                        addr_q <= addrInc;
                    end
                end
                ST_DRAIN: begin
                    if (cmpLast) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    refmem_sweep_cmp #(
        .KW    (KW),
        .ERR_W (ERR_W)
    ) u_cmp (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (startAccept),
        .outreg_i       (outreg_q),
        .ecc_i          (ecc_q),
        .width_i        (width_q),
        .seed_i         (seed_q),
        .lastK_i        (lastK_q),
        .issueValid_i   (re_q),
        .issueK_i       (k_q),
        .issueAddr_i    (addr_q),
        .rddata_i       (ram_rddata_i),
        .cmpLast_o      (cmpLast),
        .errCnt_o       (err_cnt_o),
        .firstErrAddr_o (first_err_addr_o)
    );

    assign ram_cs_o      = cs_q;
    assign ram_we_o      = we_q;
    assign ram_re_o      = re_q;
    assign ram_addr_o    = addr_q;
    assign ram_wrdata_o  = wrdata_q;
    assign ram_bitmask_o = bitmask_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cfg_err_o     = cfgErr_q;

endmodule

// File: tb/tb_refmem_port_sweeper.sv
// Scoreboard bench for refmem_port_sweeper with a behavioural block-RAM port model
// that can flip selected read bits to inject mismatches.
module tb_refmem_port_sweeper;
    localparam int LEN_W = 16;
    localparam int ERR_W = 16;
    localparam int WB_TAB [8] = '{0, 1, 2, 5, 10, 20, 40, 80};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       cfgWidth = '0;
    logic             cfgOutreg = 1'b0;
    logic             cfgEcc = 1'b0;
    logic [LEN_W-1:0] cfgLen = '0;
    logic [15:0]      cfgSeed = '0;
    logic             ramCs, ramWe, ramRe;
    logic [15:0]      ramAddr;
    logic [79:0]      ramWrData, ramBitmask, ramRdData;
    logic             busy, done, cfgErr;
    logic [ERR_W-1:0] errCnt;
    logic [15:0]      firstErrAddr;

    refmem_port_sweeper #(
        .LEN_W (LEN_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .cfg_width_i      (cfgWidth),
        .cfg_outreg_i     (cfgOutreg),
        .cfg_ecc_i        (cfgEcc),
        .cfg_len_i        (cfgLen),
        .cfg_seed_i       (cfgSeed),
        .ram_cs_o         (ramCs),
        .ram_we_o         (ramWe),
        .ram_re_o         (ramRe),
        .ram_addr_o       (ramAddr),
        .ram_wrdata_o     (ramWrData),
        .ram_bitmask_o    (ramBitmask),
        .ram_rddata_i     (ramRdData),
        .busy_o           (busy),
        .done_o           (done),
        .cfg_err_o        (cfgErr),
        .err_cnt_o        (errCnt),
        .first_err_addr_o (firstErrAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [79:0] data;
        logic [79:0] mask;
    } wr_t;

    typedef struct {
        int startEdge;
        int doneCycle;
        int csBase;
        int csCycles;
        int errCnt;
        int firstAddr;
        bit cfgErr;
        bit checkLast;
        int lastAddr;
    } res_t;

    wr_t         writeQ[$];
    res_t        resultQ[$];
    int          errors = 0;
    int          checks = 0;
    int          edgeCnt = 0;
    int          csCount = 0;
    int          runsChecked = 0;
    logic [15:0] lastWrAddr = '0;
    bit          checkWrites = 1'b0;
    logic [79:0] flipMask = '0;
    bit          flipAll = 1'b0;
    int          flipAddr = -1;
    bit          memOutreg = 1'b0;
    logic [79:0] mem [0:65535];
    logic [79:0] rdStage = '0;
    logic [79:0] rdOutReg = '0;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Memory port model: one cycle read latency, plus one more with the output register.
    always @(posedge clk) begin
        if (ramCs && ramWe)
            mem[ramAddr] <= (mem[ramAddr] & ~ramBitmask) | (ramWrData & ramBitmask);
        if (ramCs && ramRe)
            rdStage <= mem[ramAddr] ^ ((flipAll || int'(ramAddr) == flipAddr) ? flipMask : 80'd0);
        rdOutReg <= rdStage;
    end
    assign ramRdData = memOutreg ? rdOutReg : rdStage;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [79:0] expPattern(input int k, input logic [15:0] seed, input int w);
        logic [15:0] kk;
        logic [79:0] m;
        kk = 16'(k);
        m  = (80'd1 << WB_TAB[w]) - 80'd1;
        return {5{kk ^ seed}} & m;
    endfunction

    // Write monitor: counts chip-select cycles and checks each write against the queue.
    always @(negedge clk) begin
        if (ramCs) csCount++;
        if (ramCs && ramWe) begin
            lastWrAddr = ramAddr;
            if (checkWrites) begin
                if (writeQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h expected no write", ramAddr);
                end else begin
                    wr_t w;
                    w = writeQ.pop_front();
                    checkOutput("wr_addr", 80'(ramAddr), 80'(w.addr));
                    checkOutput("wr_data", ramWrData, w.data);
                    checkOutput("wr_mask", ramBitmask, w.mask);
                end
            end
        end
    end

    // Result monitor: on each rising done, pops the expected run outcome and compares.
    initial begin
        logic prevDone;
        res_t r;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prevDone) begin
                if (resultQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done at edge %0d expected none", edgeCnt);
                end else begin
                    r = resultQ.pop_front();
                    checkOutput("done_cycle", 80'(edgeCnt - r.startEdge), 80'(r.doneCycle));
                    checkOutput("cfg_err", 80'(cfgErr), 80'(r.cfgErr));
                    checkOutput("busy_at_done", 80'(busy), 80'(0));
                    checkOutput("cs_cycles", 80'(csCount - r.csBase), 80'(r.csCycles));
                    checkOutput("writes_pending", 80'(writeQ.size()), 80'(0));
                    if (r.checkLast)
                        checkOutput("last_wr_addr", 80'(lastWrAddr), 80'(r.lastAddr));
                    repeat (2) @(negedge clk);
                    checkOutput("err_cnt", 80'(errCnt), 80'(r.errCnt));
                    checkOutput("first_err_addr", 80'(firstErrAddr), 80'(r.firstAddr));
                    checkOutput("done_held", 80'(done), 80'(1));
                    runsChecked++;
                end
            end
            prevDone = done;
        end
    end

    task automatic applyStimulus(input logic [2:0] w, input logic outreg, input logic ecc,
                                 input int len, input logic [15:0] seed,
                                 input logic [79:0] fMask, input bit fAll, input int fAddr,
                                 input bit chkWr, input int expErr, input int expFirst,
                                 input int midStart);
        int   n, d, lat, expCycle, target;
        res_t r;
        if (w == 3'd0) begin
            n        = 0;
            expCycle = 1;
        end else begin
            d        = 65536 >> w;
            n        = (len == 0 || len > d) ? d : len;
            lat      = 1 + int'(outreg);
            expCycle = 2 * n + lat + 1;
        end
        if (chkWr) begin
            for (int k = 0; k < n; k++) begin
                wr_t e;
                e.addr = 16'(k << w);
                e.data = expPattern(k, seed, int'(w));
                e.mask = (80'd1 << WB_TAB[w]) - 80'd1;
                writeQ.push_back(e);
            end
        end
        @(negedge clk);
        checkWrites = chkWr;
        flipMask    = fMask;
        flipAll     = fAll;
        flipAddr    = fAddr;
        memOutreg   = outreg;
        cfgWidth    = w;
        cfgOutreg   = outreg;
        cfgEcc      = ecc;
        cfgLen      = LEN_W'(len);
        cfgSeed     = seed;
        start       = 1'b1;
        r.startEdge = edgeCnt;
        r.doneCycle = expCycle;
        r.csBase    = csCount;
        r.csCycles  = 2 * n;
        r.errCnt    = expErr;
        r.firstAddr = expFirst;
        r.cfgErr    = (w == 3'd0);
        r.checkLast = (n > 0);
        r.lastAddr  = (n > 0) ? ((n - 1) << w) & 16'hFFFF : 0;
        target      = runsChecked + 1;
        resultQ.push_back(r);
        @(negedge clk);
        start = 1'b0;
        if (midStart > 0) begin
            repeat (midStart - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < expCycle + 20 && runsChecked < target; i++) @(negedge clk);
        checkOutput("run_complete", 80'(runsChecked >= target), 80'(1));
        if (runsChecked < target) begin
            resultQ.delete();
            writeQ.delete();
        end
    endtask

    task automatic applyResetMidRun();
        @(negedge clk);
        checkWrites = 1'b0;
        flipAll     = 1'b0;
        flipAddr    = -1;
        cfgWidth    = 3'd7;
        cfgOutreg   = 1'b0;
        cfgEcc      = 1'b0;
        cfgLen      = LEN_W'(8);
        cfgSeed     = 16'h0000;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pre_busy", 80'(busy), 80'(1));
        checkOutput("rst_pre_we", 80'(ramWe), 80'(1));
        checkOutput("rst_pre_addr", 80'(ramAddr), 80'(16'h0100));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_cs", 80'(ramCs), 80'(0));
        checkOutput("rst_mid_we", 80'(ramWe), 80'(0));
        checkOutput("rst_mid_busy", 80'(busy), 80'(0));
        checkOutput("rst_mid_done", 80'(done), 80'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_idle_cs", 80'(ramCs), 80'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_cs", 80'(ramCs), 80'(0));
        checkOutput("reset_we", 80'(ramWe), 80'(0));
        checkOutput("reset_re", 80'(ramRe), 80'(0));
        checkOutput("reset_addr", 80'(ramAddr), 80'(0));
        checkOutput("reset_wrdata", ramWrData, 80'(0));
        checkOutput("reset_bitmask", ramBitmask, 80'(0));
        checkOutput("reset_busy", 80'(busy), 80'(0));
        checkOutput("reset_done", 80'(done), 80'(0));
        checkOutput("reset_cfg_err", 80'(cfgErr), 80'(0));
        checkOutput("reset_err_cnt", 80'(errCnt), 80'(0));
        checkOutput("reset_first_err", 80'(firstErrAddr), 80'(0));

        // 80b nominal: addresses 0x0000/0x0080/0x0100/0x0180, done in cycle 10
        applyStimulus(3'd7, 1'b0, 1'b0, 4, 16'h0000, 80'd0, 1'b0, -1, 1'b1, 0, 0, 0);
        // 10b, seed 0x00A5, bit 0 flipped on read k=3 (address 0x0030)
        applyStimulus(3'd4, 1'b0, 1'b0, 8, 16'h00A5, 80'd1, 1'b0, 16'h0030, 1'b1, 1, 16'h0030, 0);
        // 80b ECC: bit 16 is a check bit, so flipping it on every read is invisible
        applyStimulus(3'd7, 1'b0, 1'b1, 4, 16'h3C3C, 80'd1 << 16, 1'b1, -1, 1'b1, 0, 0, 0);
        // 80b ECC: bit 20 carries data, both reads mismatch
        applyStimulus(3'd7, 1'b0, 1'b1, 2, 16'h0000, 80'd1 << 20, 1'b1, -1, 1'b1, 2, 16'h0000, 0);
        // 5b with output register, bit 4 flipped at k=5 (address 0x0028)
        applyStimulus(3'd3, 1'b1, 1'b0, 6, 16'h00FF, 80'd1 << 4, 1'b0, 16'h0028, 1'b1, 1, 16'h0028, 0);
        // 20b with output register, start pulse in cycle 7 (READ) must be ignored
        applyStimulus(3'd5, 1'b1, 1'b0, 5, 16'h1234, 80'd0, 1'b0, -1, 1'b1, 0, 0, 7);
        applyResetMidRun();
        // Illegal width from IDLE: done and cfg_err in cycle 1, no chip select
        applyStimulus(3'd0, 1'b0, 1'b0, 4, 16'h0000, 80'd0, 1'b0, -1, 1'b1, 0, 0, 0);
        // 1b full depth with output register: 32768 entries, last write 0xFFFE
        applyStimulus(3'd1, 1'b1, 1'b0, 0, 16'h5A5A, 80'd0, 1'b0, -1, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
